serial_bypass_subtractor: RTL and testbench

- Digit-serial subtractor: computes d = a - b - b_in on WIDTH-bit operands, one 4-bit group per clock, LSB group first.
- Each group uses ripple borrow with a borrow-bypass mux: when every bit of the group propagates, the group's borrow-out is its borrow-in.
- Sits beside the combinational 4-bit bypass adders as the area-lean subtract datapath. Uses a start/busy/done handshake.

---
 rtl/sbs_pkg.sv | 22 ++
 rtl/serial_bypass_subtractor_if.sv | 31 +++
 rtl/subtract_group.sv | 32 +++
 rtl/serial_bypass_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_bypass_subtractor.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/sbs_pkg.sv
// Shared definitions for the digit-serial bypass subtractor datapath.
package sbs_pkg;

  localparam int GROUP_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Width of a counter that must hold every value 0..ngroups.
  function automatic int skips_w(input int ngroups);
    return $clog2(ngroups + 1);
  endfunction

  // Group index width, kept at least one bit for the single-group case.
  function automatic int idx_w(input int ngroups);
    return (ngroups > 1) ? $clog2(ngroups) : 1;
  endfunction

endpackage

// File: rtl/serial_bypass_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
interface serial_bypass_subtractor_if
  import sbs_pkg::*;
#(
  parameter int WIDTH = 16
);

  localparam int NGROUPS = WIDTH / GROUP_W;
  localparam int SKW     = skips_w(NGROUPS);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             b_out;
  logic [SKW-1:0]   skips;

  modport master (
    output start, a, b, b_in,
    input  busy, done, d, b_out, skips
  );

  modport slave (
    input  start, a, b, b_in,
    output busy, done, d, b_out, skips
  );

endinterface

// File: rtl/subtract_group.sv
// Combinational 4-bit ripple-borrow subtractor with a borrow-bypass mux.
module subtract_group
  import sbs_pkg::*;
(
  input  logic [GROUP_W-1:0] x,
  input  logic [GROUP_W-1:0] y,
  input  logic               bin,
  output logic [GROUP_W-1:0] diff,
  output logic               bout,
  output logic               bypass
);

  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] g;
  logic [GROUP_W:0]   br;

  assign p = ~(x ^ y);
  assign g = ~x & y;

  always_comb begin
    br[0] = bin;
    for (int unsigned i = 0; i < GROUP_W; i++) begin
      br[i+1] = g[i] | (p[i] & br[i]);
    end
  end

  assign diff   = x ^ y ^ br[GROUP_W-1:0];
  assign bypass = &p;
  // Explicit mux: when the whole group propagates, borrow-in skips the ripple chain.
  assign bout   = bypass ? bin : br[GROUP_W];

endmodule

// File: rtl/serial_bypass_subtractor.sv
// Digit-serial d = a - b - b_in, one 4-bit group per clock, LSB group first.
module serial_bypass_subtractor
  import sbs_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  serial_bypass_subtractor_if.slave   bus
);

  localparam int NGROUPS = WIDTH / GROUP_W;
  localparam int SKW     = skips_w(NGROUPS);
  localparam int IDXW    = idx_w(NGROUPS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NGROUPS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [SKW-1:0]   skips_q, skips_d;

  logic [GROUP_W-1:0] grp_x;
  logic [GROUP_W-1:0] grp_y;
  logic [GROUP_W-1:0] grp_diff;
  logic               grp_bout;
  logic               grp_bypass;

  // Operand group selection for the single time-multiplexed group slice.
  always_comb begin
    grp_x = '0;
    grp_y = '0;
    for (int unsigned gi = 0; gi < NGROUPS; gi++) begin
      if (idx_q == IDXW'(gi)) begin
        grp_x = a_q[gi*GROUP_W +: GROUP_W];
        grp_y = b_q[gi*GROUP_W +: GROUP_W];
      end
    end
  end

  subtract_group u_group (
    .x      (grp_x),
    .y      (grp_y),
    .bin    (borrow_q),
    .diff   (grp_diff),
    .bout   (grp_bout),
    .bypass (grp_bypass)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    skips_d  = skips_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = RUN;
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.b_in;
          acc_d    = '0;
          idx_d    = '0;
          skips_d  = '0;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        for (int unsigned gi = 0; gi < NGROUPS; gi++) begin
          if (idx_q == IDXW'(gi)) begin
            acc_d[gi*GROUP_W +: GROUP_W] = grp_diff;
          end
        end
        borrow_d = grp_bout;
        skips_d  = skips_q + SKW'(grp_bypass);
        idx_d    = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          bout_d  = grp_bout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      skips_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      skips_q  <= skips_d;
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.d     = acc_q;
  assign bus.b_out = bout_q;
  assign bus.skips = skips_q;

endmodule

// File: tb/tb_serial_bypass_subtractor.sv
// Self-checking bench: directed plan cases plus random operands vs an arithmetic model.
module tb_serial_bypass_subtractor;

  localparam int W  = 16;
  localparam int NG = W / 4;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  serial_bypass_subtractor_if #(.WIDTH(W)) bus ();

  serial_bypass_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction; a group bypasses exactly when its nibbles match.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] ed, output logic eb, output int es);
    int diff;
    logic [W-1:0] xa, xb;
    diff = int'(ma) - int'(mb) - int'(mbin);
    ed   = W'(diff);
    eb   = (diff < 0);
    es   = 0;
    xa   = ma;
    xb   = mb;
    for (int g = 0; g < NG; g++)
      if (xa[g*4 +: 4] == xb[g*4 +: 4]) es++;
  endtask

  // prestarted: start already accepted at the previous edge (back-to-back).
  // poke_k: cycle in which a stray start with other operands is pulsed while busy.
  // chain: raise start with (na, nb) before done and return in the done cycle, start still high.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tbin, input bit prestarted, input int poke_k,
                        input bit chain, input logic [W-1:0] na, input logic [W-1:0] nb);
    logic [W-1:0] ed;
    logic         eb;
    int           es;
    int           busy_cnt, done_cnt, done_k;
    model(ta, tb_, tbin, ed, eb, es);
    if (!prestarted) begin
      @(negedge clk);
      bus.start = 1'b1; bus.a = ta; bus.b = tb_; bus.b_in = tbin;
    end
    busy_cnt = 0; done_cnt = 0; done_k = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 1) chk({tag, ".busy1"}, 32'(bus.busy), 32'd1);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_k == 0) begin
          done_k = k;
          chk({tag, ".d"}, 32'(bus.d), 32'(ed));
          chk({tag, ".b_out"}, 32'(bus.b_out), 32'(eb));
          chk({tag, ".skips"}, 32'(bus.skips), 32'(es));
          if (chain) break;
        end
      end
      if (k == poke_k) begin
        bus.start = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h5555; bus.b_in = 1'b1;
      end
      if (k == poke_k + 1) begin
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
      end
      if (chain && k == NG) begin
        bus.start = 1'b1; bus.a = na; bus.b = nb; bus.b_in = 1'b0;
      end
      if (!chain && k == 12) chk({tag, ".d_held"}, 32'(bus.d), 32'(ed));
    end
    chk({tag, ".latency"}, 32'(done_k), 32'(NG + 1));
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(NG));
    chk({tag, ".done_pulses"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb, mask;
    int           dcnt;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.b_in = 1'b0;
    #12;
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.d", 32'(bus.d), 32'd0);
    chk("reset.b_out", 32'(bus.b_out), 32'd0);
    chk("reset.skips", 32'(bus.skips), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("basic", 16'h1234, 16'h0234, 1'b0, 1'b0, 0, 1'b0, '0, '0);
    run_op("underflow", 16'h0000, 16'h0001, 1'b0, 1'b0, 0, 1'b0, '0, '0);
    run_op("bypass_all", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0, '0, '0);
    run_op("busy_prot", 16'h0010, 16'h0001, 1'b0, 1'b0, 2, 1'b0, '0, '0);
    run_op("b2b_first", 16'h0F00, 16'h0E01, 1'b1, 1'b0, 0, 1'b1, 16'h8000, 16'h0001);
    run_op("b2b_second", 16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0, '0, '0);

    // Asynchronous reset between edges during the second busy cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h9876; bus.b = 16'h1234; bus.b_in = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_mid.busy_before", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.busy", 32'(bus.busy), 32'd0);
    chk("rst_mid.done", 32'(bus.done), 32'd0);
    chk("rst_mid.d", 32'(bus.d), 32'd0);
    chk("rst_mid.b_out", 32'(bus.b_out), 32'd0);
    chk("rst_mid.skips", 32'(bus.skips), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dcnt++;
    end
    chk("rst_mid.no_activity", 32'(dcnt), 32'd0);

    for (int n = 0; n < 20; n++) begin
      ra   = W'($urandom);
      mask = W'($urandom);
      for (int g = 0; g < NG; g++)
        if ($urandom_range(0, 1) == 0) mask[g*4 +: 4] = 4'h0;
      rb = ra ^ mask;
      if (n % 5 == 0) rb = W'($urandom);
      run_op($sformatf("rand%0d", n), ra, rb, 1'($urandom_range(0, 1)), 1'b0, 0, 1'b0, '0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
